durbin_coeff_collector: RTL and testbench

//  Consumer end of the Durbin coefficient-store unload stream. Captures the serial

---
 rtl/durbin_coeff_collector_if.sv | 27 ++
 rtl/durbin_coeff_collector.sv | 131 +++++++++++++
 tb/tb_durbin_coeff_collector.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/durbin_coeff_collector_if.sv
// durbin_coeff_collector_if: coefficient unload stream (store side) and the parallel
// coefficient bank handed to the residual filter / LPC subframe writer.
interface durbin_coeff_collector_if #(
  parameter int MAX_ORDER = 12,
  parameter int CW        = 12
);
  logic [CW-1:0]           iCoeff;
  logic                    iValid;
  logic                    iDone;
  logic [3:0]              iBestM;
  logic                    iAck;
  logic [MAX_ORDER*CW-1:0] oCoeffs;
  logic [3:0]              oOrder;
  logic [3:0]              oPrecision;
  logic                    oReady;
  logic                    oError;

  modport master (
    output iCoeff, iValid, iDone, iBestM, iAck,
    input  oCoeffs, oOrder, oPrecision, oReady, oError
  );

  modport slave (
    input  iCoeff, iValid, iDone, iBestM, iAck,
    output oCoeffs, oOrder, oPrecision, oReady, oError
  );
endinterface

// File: rtl/durbin_coeff_collector.sv
// durbin_coeff_collector: gathers the serial Durbin coefficients into a parallel bank and
// holds it under a ready/ack handshake. Define DURBIN_PRECISION_EN to track qlp precision.
module durbin_coeff_collector #(
  parameter int MAX_ORDER = 12,
  parameter int CW        = 12
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iEnable,
  durbin_coeff_collector_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [MAX_ORDER*CW-1:0] bank_q, bank_d;
  logic [3:0]              count_q, count_d;
  logic [3:0]              order_q, order_d;
  logic                    error_q, error_d;

  always_comb begin
    // NOTE: every variable written here gets its default first, so no path can infer a latch.
    state_d = state_q;
    bank_d  = bank_q;
    count_d = count_q;
    order_d = order_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.iValid) begin
          bank_d         = '0;
          bank_d[CW-1:0] = bus.iCoeff;
          count_d        = 4'd1;
          error_d        = 1'b0;
          if (bus.iDone) begin
            state_d = S_HOLD;
            order_d = 4'd1;
            error_d = (bus.iBestM != 4'd1);
          end else begin
            state_d = S_COLLECT;
          end
        end else if (bus.iDone) begin
          // Empty frame: nothing captured, bank left as it was.
          state_d = S_HOLD;
          count_d = '0;
          order_d = '0;
          error_d = (bus.iBestM != 4'd0);
        end
      end
      S_COLLECT: begin
        if (bus.iValid) begin
          if (count_q == 4'(MAX_ORDER)) begin
            error_d = 1'b1;
          end else begin
            for (int k = 0; k < MAX_ORDER; k++)
              if (count_q == 4'(k)) bank_d[k*CW +: CW] = bus.iCoeff;
            count_d = count_q + 4'd1;
          end
        end
        // A word arriving with iDone is already folded into count_d.
        if (bus.iDone) begin
          state_d = S_HOLD;
          order_d = count_d;
          if (count_d != bus.iBestM) error_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.iValid) error_d = 1'b1;
        if (bus.iAck)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= S_IDLE;
      // NOTE: the bank is a flop array visible at the outputs, so it must be reset like any register.
      bank_q  <= '0;
      count_q <= '0;
      order_q <= '0;
      error_q <= 1'b0;
    end else if (iEnable) begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q <= state_d;
      bank_q  <= bank_d;
      count_q <= count_d;
      order_q <= order_d;
      error_q <= error_d;
    end
  end

`ifdef DURBIN_PRECISION_EN
  // Minimum signed width: one sign bit above the highest bit that differs from the sign.
  function automatic logic [3:0] signed_width(input logic [CW-1:0] v);
    logic [CW-1:0] mag;
    logic [3:0]    w;
    mag = v ^ {CW{v[CW-1]}};
    w   = 4'd1;
    for (int b = 0; b < CW; b++)
      if (mag[b]) w = 4'(b + 2);
    return w;
  endfunction

  logic [3:0] prec_q, word_prec;
  logic       prec_seed, prec_grow;

  assign word_prec = signed_width(bus.iCoeff);
  assign prec_seed = (state_q == S_IDLE) && bus.iValid;
  assign prec_grow = (state_q == S_COLLECT) && bus.iValid && (count_q != 4'(MAX_ORDER));

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      prec_q <= 4'd1;
    end else if (iEnable) begin
      if (prec_seed)                             prec_q <= word_prec;
      else if (prec_grow && word_prec > prec_q)  prec_q <= word_prec;
    end
  end

  assign bus.oPrecision = prec_q;
`else
  assign bus.oPrecision = 4'(CW);
`endif

  assign bus.oCoeffs = bank_q;
  assign bus.oOrder  = order_q;
  assign bus.oReady  = (state_q == S_HOLD);
  assign bus.oError  = error_q;

endmodule

// File: tb/tb_durbin_coeff_collector.sv
// tb_durbin_coeff_collector: directed and randomized frames against a frame-level
// reference model (captured list, order, error, precision).
`timescale 1ns/1ps
module tb_durbin_coeff_collector;
  localparam int MAX_ORDER = 12;
  localparam int CW        = 12;
`ifdef DURBIN_PRECISION_EN
  localparam bit PREC_EN = 1'b1;
`else
  localparam bit PREC_EN = 1'b0;
`endif

  logic iClock = 1'b0;
  logic iReset;
  logic iEnable;

  durbin_coeff_collector_if #(.MAX_ORDER(MAX_ORDER), .CW(CW)) bus ();

  durbin_coeff_collector #(.MAX_ORDER(MAX_ORDER), .CW(CW)) dut (
    .iClock  (iClock),
    .iReset  (iReset),
    .iEnable (iEnable),
    .bus     (bus)
  );

  always #5 iClock = ~iClock;

  int total = 0;
  int bad   = 0;

  int                      frame_q[$];
  logic [MAX_ORDER*CW-1:0] exp_bank;
  logic [3:0]              exp_order;
  logic [3:0]              exp_prec;
  logic                    exp_err;

  // Smallest w with -2^(w-1) <= v <= 2^(w-1)-1.
  function automatic int width_of(int v);
    for (int w = 1; w < CW; w++)
      if (v >= -(1 << (w - 1)) && v <= (1 << (w - 1)) - 1) return w;
    return CW;
  endfunction

  // Expected bank state for the words in frame_q, given the requested order.
  function automatic void model_frame(int best_m);
    int n, kept, pw;
    n    = frame_q.size();
    kept = (n > MAX_ORDER) ? MAX_ORDER : n;
    pw   = 1;
    exp_bank = '0;
    for (int k = 0; k < kept; k++) begin
      exp_bank[k*CW +: CW] = CW'(frame_q[k]);
      if (width_of(frame_q[k]) > pw) pw = width_of(frame_q[k]);
    end
    exp_order = 4'(kept);
    exp_err   = (n > MAX_ORDER) || (kept != best_m);
    exp_prec  = PREC_EN ? 4'(pw) : 4'(CW);
  endfunction

  function automatic int rand_word();
    int w;
    w = int'($urandom_range(1, CW));
    return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
  endfunction

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iValid = 1'b0;
    bus.iDone  = 1'b0;
    bus.iAck   = 1'b0;
    bus.iCoeff = '0;
  endtask

  // Drives frame_q as one frame; noisy adds gaps, enable-low junk and stray iAck.
  task automatic send_frame(int best_m, bit done_with_last, bit noisy);
    bus.iBestM = 4'(best_m);
    foreach (frame_q[i]) begin
      if (noisy && $urandom_range(0, 3) == 0) begin
        iEnable    = 1'b0;
        bus.iValid = 1'b1;
        bus.iDone  = 1'($urandom_range(0, 1));
        bus.iAck   = 1'b1;
        bus.iCoeff = CW'($urandom);
        tick();
        iEnable = 1'b1;
      end
      if (noisy && $urandom_range(0, 3) == 0) begin
        idle_inputs();
        bus.iAck = 1'($urandom_range(0, 1));
        tick();
      end
      bus.iValid = 1'b1;
      bus.iCoeff = CW'(frame_q[i]);
      bus.iAck   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.iDone  = done_with_last && (i == frame_q.size() - 1);
      tick();
    end
    if (!done_with_last) begin
      idle_inputs();
      total++; if (bus.oReady !== 1'b0) begin bad++; $display("FAIL ready_before_done got=%b exp=0", bus.oReady); end
      bus.iDone = 1'b1;
      tick();
    end
    idle_inputs();
    model_frame(best_m);
  endtask

  task automatic do_ack();
    bus.iAck = 1'b1;
    tick();
    bus.iAck = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.oCoeffs !== '0)   begin bad++; $display("FAIL reset coeffs got=%h exp=0", bus.oCoeffs); end
    total++; if (bus.oOrder !== 4'd0)  begin bad++; $display("FAIL reset order got=%0d exp=0", bus.oOrder); end
    total++; if (bus.oPrecision !== (PREC_EN ? 4'd1 : 4'(CW))) begin bad++; $display("FAIL reset prec got=%0d", bus.oPrecision); end
    total++; if (bus.oReady !== 1'b0)  begin bad++; $display("FAIL reset ready got=%b exp=0", bus.oReady); end
    total++; if (bus.oError !== 1'b0)  begin bad++; $display("FAIL reset error got=%b exp=0", bus.oError); end
  endtask

  task automatic test_basic();
    frame_q = '{3, -5, 100, -2048};
    send_frame(4, 1'b0, 1'b0);
    total++; if (bus.oReady !== 1'b1)        begin bad++; $display("FAIL basic ready got=%b exp=1", bus.oReady); end
    total++; if (bus.oOrder !== exp_order)   begin bad++; $display("FAIL basic order got=%0d exp=%0d", bus.oOrder, exp_order); end
    total++; if (bus.oCoeffs !== exp_bank)   begin bad++; $display("FAIL basic bank got=%h exp=%h", bus.oCoeffs, exp_bank); end
    total++; if (bus.oPrecision !== exp_prec) begin bad++; $display("FAIL basic prec got=%0d exp=%0d", bus.oPrecision, exp_prec); end
    total++; if (bus.oError !== exp_err)     begin bad++; $display("FAIL basic error got=%b exp=%b", bus.oError, exp_err); end
    do_ack();
    total++; if (bus.oReady !== 1'b0)        begin bad++; $display("FAIL basic ack_ready got=%b exp=0", bus.oReady); end
    total++; if (bus.oCoeffs !== exp_bank)   begin bad++; $display("FAIL basic retained got=%h exp=%h", bus.oCoeffs, exp_bank); end
  endtask

  task automatic test_short();
    frame_q = '{1, -1};
    send_frame(3, 1'b0, 1'b0);
    total++; if (bus.oOrder !== exp_order)    begin bad++; $display("FAIL short order got=%0d exp=%0d", bus.oOrder, exp_order); end
    total++; if (bus.oError !== exp_err)      begin bad++; $display("FAIL short error got=%b exp=%b", bus.oError, exp_err); end
    total++; if (bus.oPrecision !== exp_prec) begin bad++; $display("FAIL short prec got=%0d exp=%0d", bus.oPrecision, exp_prec); end
    total++; if (bus.oCoeffs !== exp_bank)    begin bad++; $display("FAIL short bank got=%h exp=%h", bus.oCoeffs, exp_bank); end
    do_ack();
  endtask

  task automatic test_same_cycle();
    frame_q = '{7};
    send_frame(1, 1'b1, 1'b0);
    total++; if (bus.oReady !== 1'b1)         begin bad++; $display("FAIL same ready got=%b exp=1", bus.oReady); end
    total++; if (bus.oOrder !== exp_order)    begin bad++; $display("FAIL same order got=%0d exp=%0d", bus.oOrder, exp_order); end
    total++; if (bus.oCoeffs !== exp_bank)    begin bad++; $display("FAIL same bank got=%h exp=%h", bus.oCoeffs, exp_bank); end
    total++; if (bus.oPrecision !== exp_prec) begin bad++; $display("FAIL same prec got=%0d exp=%0d", bus.oPrecision, exp_prec); end
    total++; if (bus.oError !== exp_err)      begin bad++; $display("FAIL same error got=%b exp=%b", bus.oError, exp_err); end
    do_ack();
  endtask

  task automatic test_overrun();
    frame_q = {};
    for (int i = 0; i < 13; i++) frame_q.push_back(1);
    send_frame(12, 1'b0, 1'b0);
    total++; if (bus.oOrder !== exp_order)    begin bad++; $display("FAIL overrun order got=%0d exp=%0d", bus.oOrder, exp_order); end
    total++; if (bus.oError !== exp_err)      begin bad++; $display("FAIL overrun error got=%b exp=%b", bus.oError, exp_err); end
    total++; if (bus.oCoeffs !== exp_bank)    begin bad++; $display("FAIL overrun bank got=%h exp=%h", bus.oCoeffs, exp_bank); end
    total++; if (bus.oPrecision !== exp_prec) begin bad++; $display("FAIL overrun prec got=%0d exp=%0d", bus.oPrecision, exp_prec); end
    do_ack();
  endtask

  task automatic test_hold_valid();
    frame_q = '{10, -20, 30};
    send_frame(3, 1'b0, 1'b0);
    total++; if (bus.oError !== 1'b0) begin bad++; $display("FAIL hold pre_error got=%b exp=0", bus.oError); end
    for (int i = 0; i < 3; i++) begin
      bus.iValid = 1'b1;
      bus.iCoeff = CW'(rand_word());
      tick();
      idle_inputs();
      tick();
    end
    total++; if (bus.oReady !== 1'b1)         begin bad++; $display("FAIL hold ready got=%b exp=1", bus.oReady); end
    total++; if (bus.oCoeffs !== exp_bank)    begin bad++; $display("FAIL hold bank got=%h exp=%h", bus.oCoeffs, exp_bank); end
    total++; if (bus.oOrder !== exp_order)    begin bad++; $display("FAIL hold order got=%0d exp=%0d", bus.oOrder, exp_order); end
    total++; if (bus.oPrecision !== exp_prec) begin bad++; $display("FAIL hold prec got=%0d exp=%0d", bus.oPrecision, exp_prec); end
    total++; if (bus.oError !== 1'b1)         begin bad++; $display("FAIL hold error got=%b exp=1", bus.oError); end
    iEnable  = 1'b0;
    bus.iAck = 1'b1;
    tick();
    iEnable  = 1'b1;
    bus.iAck = 1'b0;
    total++; if (bus.oReady !== 1'b1) begin bad++; $display("FAIL hold gated_ack got=%b exp=1", bus.oReady); end
    do_ack();
    total++; if (bus.oReady !== 1'b0) begin bad++; $display("FAIL hold ack_ready got=%b exp=0", bus.oReady); end
  endtask

  task automatic test_reset_mid();
    frame_q = '{};
    for (int i = 0; i < 5; i++) frame_q.push_back(rand_word() | 1);
    bus.iBestM = 4'd5;
    foreach (frame_q[i]) begin
      bus.iValid = 1'b1;
      bus.iCoeff = CW'(frame_q[i]);
      tick();
    end
    idle_inputs();
    #2 iReset = 1'b0;
    #1;
    test_reset();
    tick();
    iReset = 1'b1;
    tick();
    frame_q = '{rand_word(), rand_word(), rand_word()};
    send_frame(3, 1'b0, 1'b0);
    total++; if (bus.oCoeffs !== exp_bank)    begin bad++; $display("FAIL post_reset bank got=%h exp=%h", bus.oCoeffs, exp_bank); end
    total++; if (bus.oOrder !== exp_order)    begin bad++; $display("FAIL post_reset order got=%0d exp=%0d", bus.oOrder, exp_order); end
    total++; if (bus.oError !== exp_err)      begin bad++; $display("FAIL post_reset error got=%b exp=%b", bus.oError, exp_err); end
    total++; if (bus.oPrecision !== exp_prec) begin bad++; $display("FAIL post_reset prec got=%0d exp=%0d", bus.oPrecision, exp_prec); end
    do_ack();
  endtask

  task automatic test_random();
    int n, best_m;
    for (int f = 0; f < 25; f++) begin
      n = int'($urandom_range(1, 13));
      frame_q = {};
      for (int i = 0; i < n; i++) frame_q.push_back(rand_word());
      best_m = ($urandom_range(0, 1) == 1) ? ((n > MAX_ORDER) ? MAX_ORDER : n) : int'($urandom_range(0, 12));
      send_frame(best_m, 1'($urandom_range(0, 1)), 1'b1);
      total++; if (bus.oReady !== 1'b1)         begin bad++; $display("FAIL rand%0d ready got=%b exp=1", f, bus.oReady); end
      total++; if (bus.oCoeffs !== exp_bank)    begin bad++; $display("FAIL rand%0d bank got=%h exp=%h", f, bus.oCoeffs, exp_bank); end
      total++; if (bus.oOrder !== exp_order)    begin bad++; $display("FAIL rand%0d order got=%0d exp=%0d", f, bus.oOrder, exp_order); end
      total++; if (bus.oError !== exp_err)      begin bad++; $display("FAIL rand%0d error got=%b exp=%b", f, bus.oError, exp_err); end
      total++; if (bus.oPrecision !== exp_prec) begin bad++; $display("FAIL rand%0d prec got=%0d exp=%0d", f, bus.oPrecision, exp_prec); end
      do_ack();
      total++; if (bus.oReady !== 1'b0)         begin bad++; $display("FAIL rand%0d ack_ready got=%b exp=0", f, bus.oReady); end
    end
  endtask

  initial begin
    iReset     = 1'b0;
    iEnable    = 1'b1;
    bus.iBestM = '0;
    idle_inputs();
    #3;
    test_reset();
    tick();
    iReset = 1'b1;
    tick();
    test_basic();
    test_short();
    test_same_cycle();
    test_overrun();
    test_hold_valid();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
